// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC receive-stream parser.
package adc_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_INFO, S_DATA, S_LRT, S_ENDB, S_DONE
  } state_e;

  localparam logic [2:0] ERR_OK   = 3'd0;
  localparam logic [2:0] ERR_HEAD = 3'd1;
  localparam logic [2:0] ERR_KIND = 3'd2;
  localparam logic [2:0] ERR_LRT  = 3'd3;
  localparam logic [2:0] ERR_END  = 3'd4;
  localparam logic [2:0] ERR_TMO  = 3'd5;

  localparam int HDR_LEN = 8;

  // Payload bytes contributed by one 2-bit chip field (2 bytes per channel).
  function automatic logic [10:0] kind2bytes(input logic [1:0] f);
    case (f)
      2'd0:    return 11'd0;
      2'd1:    return 11'd64;
      2'd2:    return 11'd128;
      default: return 11'd256;
    endcase
  endfunction

  // Highest non-null chip strictly below 'start' (0 when none is left).
  function automatic logic [1:0] next_chip(input logic [7:0] kind, input logic [2:0] start);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 4; k++)
      if (3'(k) < start && kind[2*k +: 2] != 2'd0) r = 2'(k);
    return r;
  endfunction

endpackage

// File: rtl/adc_rx_timeout.sv
// Inter-byte idle counter; expire pulses on the TIMEOUT-th consecutive idle cycle.
module adc_rx_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) cnt_d = '0;
    else            cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = en && !clr && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/adc_rx_parser.sv
// Parses the ADC byte stream: header check, device info capture, sample unpacking,
// LRT/END verification, with fs_/fd_ start/done handshake.
module adc_rx_parser import adc_pkg::*; #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_parse,
  output logic        fd_parse,
  input  logic        adc_rxen,
  input  logic [7:0]  adc_rxd,
  input  logic [63:0] adc_cmd,
  input  logic [7:0]  adc_end,
  output logic [7:0]  hdr_smpr,
  output logic [7:0]  hdr_info,
  output logic [7:0]  hdr_kind,
  output logic        smp_valid,
  output logic [1:0]  smp_chip,
  output logic [6:0]  smp_chan,
  output logic [15:0] smp_data,
  output logic [2:0]  err
);

  state_e      state_q, state_d;
  logic [10:0] bcnt_q, bcnt_d;
  logic [10:0] len_q, len_d;
  logic [1:0]  chip_q, chip_d;
  logic [7:0]  cbyte_q, cbyte_d;
  logic [7:0]  lrt_q, lrt_d;
  logic [7:0]  data_hi_q, data_hi_d;
  logic [7:0]  smpr_q, smpr_d, info_q, info_d, kind_q, kind_d;
  logic        smp_valid_q, smp_valid_d;
  logic [1:0]  smp_chip_q, smp_chip_d;
  logic [6:0]  smp_chan_q, smp_chan_d;
  logic [15:0] smp_data_q, smp_data_d;
  logic [2:0]  err_q, err_d;
  logic        fd_q, fd_d;

  logic        tmo_en, expire;
  logic [5:0]  hdr_sh;
  logic [7:0]  exp_hdr;
  logic [10:0] chip_len, kind_len;

  assign tmo_en = (state_q != S_IDLE) && (state_q != S_DONE);

  adc_rx_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (adc_rxen),
    .en     (tmo_en),
    .expire (expire)
  );

  // Header is sent MSB byte first: byte i sits at adc_cmd[63-8i -: 8].
  assign hdr_sh   = {3'd7 - bcnt_q[2:0], 3'b000};
  assign exp_hdr  = adc_cmd[hdr_sh +: 8];
  assign chip_len = kind2bytes(kind_q[{chip_q, 1'b0} +: 2]);
  assign kind_len = kind2bytes(adc_rxd[7:6]) + kind2bytes(adc_rxd[5:4])
                  + kind2bytes(adc_rxd[3:2]) + kind2bytes(adc_rxd[1:0]);

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    len_d       = len_q;
    chip_d      = chip_q;
    cbyte_d     = cbyte_q;
    lrt_d       = lrt_q;
    data_hi_d   = data_hi_q;
    smpr_d      = smpr_q;
    info_d      = info_q;
    kind_d      = kind_q;
    smp_valid_d = 1'b0;
    smp_chip_d  = smp_chip_q;
    smp_chan_d  = smp_chan_q;
    smp_data_d  = smp_data_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: if (fs_parse) begin
        state_d = S_HEAD;
        bcnt_d  = '0;
        lrt_d   = '0;
        err_d   = ERR_OK;
      end
      S_HEAD: if (adc_rxen) begin
        if (adc_rxd != exp_hdr) begin
          state_d = S_DONE;
          err_d   = ERR_HEAD;
        end else if (bcnt_q == 11'(HDR_LEN - 1)) begin
          state_d = S_INFO;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 11'd1;
        end
      end
      S_INFO: if (adc_rxen) begin
        lrt_d  = lrt_q ^ adc_rxd;
        bcnt_d = bcnt_q + 11'd1;
        case (bcnt_q[1:0])
          2'd0: smpr_d = adc_rxd;
          2'd1: info_d = adc_rxd;
          default: begin
            kind_d  = adc_rxd;
            len_d   = kind_len;
            chip_d  = next_chip(adc_rxd, 3'd4);
            cbyte_d = '0;
            bcnt_d  = '0;
            state_d = (kind_len == 11'd0) ? S_LRT : S_DATA;
          end
        endcase
      end
      S_DATA: if (adc_rxen) begin
        lrt_d   = lrt_q ^ adc_rxd;
        bcnt_d  = bcnt_q + 11'd1;
        cbyte_d = cbyte_q + 8'd1;
        if (!cbyte_q[0]) begin
          data_hi_d = adc_rxd;
        end else begin
          smp_valid_d = 1'b1;
          smp_chip_d  = chip_q;
          smp_chan_d  = cbyte_q[7:1];
          smp_data_d  = {data_hi_q, adc_rxd};
        end
        if ({3'b000, cbyte_q} == chip_len - 11'd1) begin
          chip_d  = next_chip(kind_q, {1'b0, chip_q});
          cbyte_d = '0;
        end
        if (bcnt_q == len_q - 11'd1) begin
          state_d = S_LRT;
          bcnt_d  = '0;
        end
      end
      S_LRT: if (adc_rxen) begin
        if (adc_rxd != lrt_q) err_d = ERR_LRT;
        state_d = S_ENDB;
      end
      S_ENDB: if (adc_rxen) begin
        // An earlier LRT failure takes priority over the end-byte check.
        if (err_q == ERR_OK && adc_rxd != adc_end) err_d = ERR_END;
        state_d = S_DONE;
      end
      S_DONE: if (!fs_parse) begin
        state_d = S_IDLE;
        err_d   = ERR_OK;
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_en && expire) begin
      state_d = S_DONE;
      err_d   = ERR_TMO;
    end

    // Losing the arm mid-frame discards everything, including a half-built sample.
    if (tmo_en && !fs_parse) begin
      state_d     = S_IDLE;
      err_d       = ERR_OK;
      bcnt_d      = '0;
      len_d       = '0;
      chip_d      = '0;
      cbyte_d     = '0;
      lrt_d       = '0;
      data_hi_d   = '0;
      smpr_d      = '0;
      info_d      = '0;
      kind_d      = '0;
      smp_valid_d = 1'b0;
      smp_chip_d  = '0;
      smp_chan_d  = '0;
      smp_data_d  = '0;
    end

    fd_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bcnt_q      <= '0;
      len_q       <= '0;
      chip_q      <= '0;
      cbyte_q     <= '0;
      lrt_q       <= '0;
      data_hi_q   <= '0;
      smpr_q      <= '0;
      info_q      <= '0;
      kind_q      <= '0;
      smp_valid_q <= 1'b0;
      smp_chip_q  <= '0;
      smp_chan_q  <= '0;
      smp_data_q  <= '0;
      err_q       <= ERR_OK;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      len_q       <= len_d;
      chip_q      <= chip_d;
      cbyte_q     <= cbyte_d;
      lrt_q       <= lrt_d;
      data_hi_q   <= data_hi_d;
      smpr_q      <= smpr_d;
      info_q      <= info_d;
      kind_q      <= kind_d;
      smp_valid_q <= smp_valid_d;
      smp_chip_q  <= smp_chip_d;
      smp_chan_q  <= smp_chan_d;
      smp_data_q  <= smp_data_d;
      err_q       <= err_d;
      fd_q        <= fd_d;
    end
  end

  assign fd_parse  = fd_q;
  assign err       = err_q;
  assign hdr_smpr  = smpr_q;
  assign hdr_info  = info_q;
  assign hdr_kind  = kind_q;
  assign smp_valid = smp_valid_q;
  assign smp_chip  = smp_chip_q;
  assign smp_chan  = smp_chan_q;
  assign smp_data  = smp_data_q;

endmodule

// File: tb/tb_adc_rx_parser.sv
// Directed bench for adc_rx_parser: frame table plus reset/abort/header-timing sequences.
module tb_adc_rx_parser;

  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs_parse = 1'b0;
  logic        adc_rxen = 1'b0;
  logic [7:0]  adc_rxd = 8'h00;
  logic [63:0] adc_cmd = 64'h0123456789ABCDEF;
  logic [7:0]  adc_end = 8'hAA;
  logic        fd_parse, smp_valid;
  logic [7:0]  hdr_smpr, hdr_info, hdr_kind;
  logic [1:0]  smp_chip;
  logic [6:0]  smp_chan;
  logic [15:0] smp_data;
  logic [2:0]  err;

  adc_rx_parser #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .fs_parse(fs_parse), .fd_parse(fd_parse),
    .adc_rxen(adc_rxen), .adc_rxd(adc_rxd), .adc_cmd(adc_cmd), .adc_end(adc_end),
    .hdr_smpr(hdr_smpr), .hdr_info(hdr_info), .hdr_kind(hdr_kind),
    .smp_valid(smp_valid), .smp_chip(smp_chip), .smp_chan(smp_chan),
    .smp_data(smp_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  chip;
    logic [6:0]  chan;
    logic [15:0] data;
  } smp_t;

  typedef struct {
    logic [7:0] kind, smpr, info, flip, endb;
    int         bad_idx;
    logic [7:0] bad_val;
    int         gap_len;
    logic [2:0] exp_err;
    int         exp_nsmp;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   nsmp_seen = 0;
  smp_t exp_q[$];
  smp_t mon_e;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (smp_valid === 1'b1) begin
      nsmp_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_sample actual chip=%0d chan=%0d data=%h required none",
                 smp_chip, smp_chan, smp_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({smp_chip, smp_chan, smp_data} !== mon_e) begin
          bad++;
          $display("FAIL sample actual=%0d/%0d/%h required=%0d/%0d/%h",
                   smp_chip, smp_chan, smp_data, mon_e.chip, mon_e.chan, mon_e.data);
        end
      end
    end
  end

  function automatic logic [7:0] pat(input int j);
    return 8'(j * 7 + 3) ^ 8'hA5;
  endfunction

  function automatic int cb(input logic [1:0] f);
    case (f)
      2'd0:    return 0;
      2'd1:    return 64;
      2'd2:    return 128;
      default: return 256;
    endcase
  endfunction

  function automatic vec_t mk(input logic [7:0] kind, smpr, info, flip, endb,
                              input int bad_idx, input logic [7:0] bad_val,
                              input int gap_len, input logic [2:0] e, input int n);
    vec_t v;
    v.kind = kind; v.smpr = smpr; v.info = info; v.flip = flip; v.endb = endb;
    v.bad_idx = bad_idx; v.bad_val = bad_val; v.gap_len = gap_len;
    v.exp_err = e; v.exp_nsmp = n;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    adc_rxen = 1'b1;
    adc_rxd  = b;
  endtask

  function automatic logic [53:0] all_outs();
    return {fd_parse, err, hdr_smpr, hdr_info, hdr_kind,
            smp_valid, smp_chip, smp_chan, smp_data};
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    logic [7:0] q[$];
    logic [7:0] b, hi, lo, lrt;
    int j;
    q = {};
    exp_q.delete();
    nsmp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      b = adc_cmd[63 - 8*i -: 8];
      if (i == v.bad_idx) b = v.bad_val;
      q.push_back(b);
    end
    q.push_back(v.smpr); q.push_back(v.info); q.push_back(v.kind);
    lrt = v.smpr ^ v.info ^ v.kind;
    j = 0;
    for (int c = 3; c >= 0; c--) begin
      for (int ch = 0; ch < cb(v.kind[2*c +: 2]) / 2; ch++) begin
        hi = pat(j);
        lo = pat(j + 1);
        q.push_back(hi);
        q.push_back(lo);
        lrt = lrt ^ hi ^ lo;
        if (exp_q.size() < v.exp_nsmp) exp_q.push_back({2'(c), 7'(ch), hi, lo});
        j += 2;
      end
    end
    q.push_back(lrt ^ v.flip);
    q.push_back(v.endb);

    @(negedge clk);
    fs_parse = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      if (v.gap_len > 0 && i == 11 + 5)
        repeat (v.gap_len) begin
          @(negedge clk);
          adc_rxen = 1'b0;
        end
      send_byte(q[i]);
    end
    @(negedge clk);
    adc_rxen = 1'b0;
    for (int k = 0; k < 4 && fd_parse !== 1'b1; k++) @(negedge clk);
    chk({nm, "_fd"}, 64'(fd_parse), 64'd1);
    chk({nm, "_err"}, 64'(err), 64'(v.exp_err));
    chk({nm, "_nsmp"}, 64'(nsmp_seen), 64'(v.exp_nsmp));
    chk({nm, "_left"}, 64'(exp_q.size()), 64'd0);
    if (v.exp_err != 3'd1)
      chk({nm, "_hdr"}, 64'({hdr_smpr, hdr_info, hdr_kind}), 64'({v.smpr, v.info, v.kind}));
    repeat (3) @(negedge clk);
    chk({nm, "_fd_hold"}, 64'({fd_parse, err}), 64'({1'b1, v.exp_err}));
    fs_parse = 1'b0;
    @(negedge clk);
    chk({nm, "_release"}, 64'({fd_parse, err}), 64'd0);
  endtask

  // Header + info (kind 0x55) + first 10 DATA bytes: five chip-3 samples.
  task automatic prelude();
    exp_q.delete();
    nsmp_seen = 0;
    @(negedge clk);
    fs_parse = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(adc_cmd[63 - 8*i -: 8]);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h55);
    for (int i = 0; i < 10; i++) begin
      send_byte(pat(i));
      if (i[0]) exp_q.push_back({2'd3, 7'(i / 2), pat(i - 1), pat(i)});
    end
    @(negedge clk);
    adc_rxen = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = mk(8'h55, 8'h11, 8'h22, 8'h00, 8'hAA, -1, 8'h00, 0,        3'd0, 128);
    vecs[1] = mk(8'h55, 8'h11, 8'h22, 8'h00, 8'hAA,  3, 8'h66, 0,        3'd1, 0);
    vecs[2] = mk(8'h00, 8'h3C, 8'hC3, 8'h00, 8'hAA, -1, 8'h00, 0,        3'd0, 0);
    vecs[3] = mk(8'hC4, 8'h5A, 8'hA5, 8'h01, 8'hAA, -1, 8'h00, 0,        3'd3, 160);
    vecs[4] = mk(8'hC4, 8'h5A, 8'hA5, 8'h00, 8'h00, -1, 8'h00, 0,        3'd4, 160);
    vecs[5] = mk(8'hC4, 8'h5A, 8'hA5, 8'h80, 8'h00, -1, 8'h00, 0,        3'd3, 160);
    vecs[6] = mk(8'h55, 8'h77, 8'h88, 8'h00, 8'hAA, -1, 8'h00, TMO,      3'd5, 2);
    vecs[7] = mk(8'h55, 8'h99, 8'h12, 8'h00, 8'hAA, -1, 8'h00, TMO - 1,  3'd0, 128);
    vecs[8] = mk(8'h06, 8'h34, 8'h56, 8'h00, 8'hAA, -1, 8'h00, 0,        3'd0, 96);
    vecs[9] = mk(8'hFF, 8'hF0, 8'h0F, 8'h00, 8'hAA, -1, 8'h00, 0,        3'd0, 512);

    repeat (2) @(negedge clk);
    chk("reset_outs", 64'(all_outs()), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Bad header byte 3: DONE right after it, held while armed.
    exp_q.delete();
    nsmp_seen = 0;
    @(negedge clk);
    fs_parse = 1'b1;
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h66);
    @(negedge clk);
    adc_rxen = 1'b0;
    chk("hdr3_done_now", 64'({fd_parse, err}), 64'({1'b1, 3'd1}));
    repeat (5) @(negedge clk);
    chk("hdr3_held", 64'({fd_parse, err, nsmp_seen[7:0]}), 64'({1'b1, 3'd1, 8'd0}));
    fs_parse = 1'b0;
    @(negedge clk);
    chk("hdr3_release", 64'({fd_parse, err}), 64'd0);

    // Reset mid-DATA.
    prelude();
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", 64'(all_outs()), 64'd0);
    chk("rst_mid_nsmp", 64'(nsmp_seen), 64'd5);
    chk("rst_mid_left", 64'(exp_q.size()), 64'd0);
    fs_parse = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[0], "after_rst");

    // fs_parse dropped mid-DATA.
    prelude();
    fs_parse = 1'b0;
    @(negedge clk);
    chk("abort_outs", 64'(all_outs()), 64'd0);
    chk("abort_nsmp", 64'(nsmp_seen), 64'd5);
    repeat (3) @(negedge clk);
    chk("abort_quiet", 64'({fd_parse, err, nsmp_seen[7:0]}), 64'({1'b0, 3'd0, 8'd5}));
    run_vec(vecs[3], "after_abort_c4");
    run_vec(vecs[0], "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
